// File: rtl/descriptor_reader.sv
// Drains the descriptor BRAM and streams each histogram word as bytes, MSB first.
// Optional DESC_CHECKSUM_EN appends a running XOR byte after the last data byte.
module descriptor_reader #(
  parameter int NUMBER_DESCRIPTORS = 4000,
  parameter int PATCH_SIZE         = 4,
  parameter int BRAM_LATENCY       = 2
) (
  input  logic                                                clk,
  input  logic                                                rst_in,
  input  logic                                                start,
  input  logic [$clog2(NUMBER_DESCRIPTORS+1)-1:0]             desc_count,
  output logic [$clog2(NUMBER_DESCRIPTORS)-1:0]               desc_read_addr,
  input  logic [($clog2(PATCH_SIZE/2*PATCH_SIZE/2)+1)*8-1:0]  desc_in,
  output logic [7:0]                                          out_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic                                                out_last,
  output logic                                                busy,
  output logic                                                reader_done
);
  localparam int AW         = $clog2(NUMBER_DESCRIPTORS);
  localparam int CW         = $clog2(NUMBER_DESCRIPTORS+1);
  localparam int DESC_WIDTH = ($clog2(PATCH_SIZE/2*PATCH_SIZE/2)+1)*8;
  localparam int NBYTES     = DESC_WIDTH/8;
  localparam int BW         = $clog2(NBYTES+1);
  localparam int LW         = $clog2(BRAM_LATENCY+1);

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND, ST_DONE} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         count, count_next, count_clamped;
  logic [AW-1:0]         addr, addr_next;
  logic [LW-1:0]         lat_cnt, lat_cnt_next;
  logic [DESC_WIDTH-1:0] word, word_next;
  logic [BW-1:0]         byte_idx, byte_idx_next;
  logic                  done_q;
  logic                  last_word;
`ifdef DESC_CHECKSUM_EN
  logic [7:0]            csum, csum_next;
`endif

  assign count_clamped = (desc_count > CW'(NUMBER_DESCRIPTORS)) ? CW'(NUMBER_DESCRIPTORS) : desc_count;
  assign last_word     = ((CW+1)'(addr) + (CW+1)'(1)) >= (CW+1)'(count);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      count    <= '0;
      addr     <= '0;
      lat_cnt  <= '0;
      word     <= '0;
      byte_idx <= '0;
      done_q   <= 1'b0;
`ifdef DESC_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_next;
      count    <= count_next;
      addr     <= addr_next;
      lat_cnt  <= lat_cnt_next;
      word     <= word_next;
      byte_idx <= byte_idx_next;
      done_q   <= (state == ST_DONE);
`ifdef DESC_CHECKSUM_EN
      csum     <= csum_next;
`endif
    end
  end

  // lat_cnt counts cycles since the address last changed; FETCH is one of them,
  // so WAIT lasts one cycle longer after start than between words.
  always_comb begin
    state_next    = state;
    count_next    = count;
    addr_next     = addr;
    lat_cnt_next  = lat_cnt;
    word_next     = word;
    byte_idx_next = byte_idx;
`ifdef DESC_CHECKSUM_EN
    csum_next     = csum;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          count_next   = count_clamped;
          addr_next    = '0;
          lat_cnt_next = '0;
`ifdef DESC_CHECKSUM_EN
          csum_next    = '0;
          if (count_clamped == '0) begin
            byte_idx_next = BW'(NBYTES);
            state_next    = ST_SEND;
          end else begin
            state_next = ST_WAIT;
          end
`else
          state_next = (count_clamped == '0) ? ST_DONE : ST_WAIT;
`endif
        end
      end
      ST_FETCH: begin
        lat_cnt_next = lat_cnt + 1'b1;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == LW'(BRAM_LATENCY)) begin
          word_next     = desc_in;
          byte_idx_next = '0;
          state_next    = ST_SEND;
        end else begin
          lat_cnt_next = lat_cnt + 1'b1;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          word_next     = word << 8;
          byte_idx_next = byte_idx + 1'b1;
`ifdef DESC_CHECKSUM_EN
          csum_next     = csum ^ out_data;
          if (byte_idx == BW'(NBYTES)) begin
            state_next = ST_DONE;
          end else if (byte_idx == BW'(NBYTES-1) && !last_word) begin
            addr_next    = addr + 1'b1;
            lat_cnt_next = '0;
            state_next   = ST_FETCH;
          end
`else
          if (byte_idx == BW'(NBYTES-1)) begin
            if (last_word) begin
              state_next = ST_DONE;
            end else begin
              addr_next    = addr + 1'b1;
              lat_cnt_next = '0;
              state_next   = ST_FETCH;
            end
          end
`endif
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign desc_read_addr = addr;
  assign out_valid      = (state == ST_SEND);
  assign busy           = (state != ST_IDLE);
  assign reader_done    = done_q;
`ifdef DESC_CHECKSUM_EN
  assign out_data = (byte_idx == BW'(NBYTES)) ? csum : word[DESC_WIDTH-1 -: 8];
  assign out_last = out_valid && last_word && (byte_idx == BW'(NBYTES));
`else
  assign out_data = word[DESC_WIDTH-1 -: 8];
  assign out_last = out_valid && last_word && (byte_idx == BW'(NBYTES-1));
`endif

endmodule
